// File: rtl/ssd_scan_driver.sv
// Time-multiplexed seven-segment driver: shadowed hex value, per-digit blanking, one dead cycle per slot.
// Optional build macro SSD_LEADING_ZERO_BLANK_EN also darkens leading zero digits (digit 0 always shown).
module ssd_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value_i,
    input  logic                  load_i,
    input  logic [DIGITS-1:0]     blank_mask_i,
    output logic [6:0]            ssd_bits_o,
    output logic [DIGITS-1:0]     digit_en_o
);
    localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {DEAD = 1'b0, DRIVE = 1'b1} phase_t;

    phase_t              state_q;
    logic [DW-1:0]       div_cnt_q;
    logic [IW-1:0]       idx_q;
    logic [4*DIGITS-1:0] value_q;
    logic [DIGITS-1:0]   mask_q;
    logic [6:0]          ssd_bits_q;
    logic [DIGITS-1:0]   digit_en_q;

    logic [3:0]          nib_d;
    logic                blank_d;
    logic [DIGITS-1:0]   sel_en_d;
    logic [IW-1:0]       idx_d;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'h0: seg_decode = 7'b1000000;
            4'h1: seg_decode = 7'b1111001;
            4'h2: seg_decode = 7'b0100100;
            4'h3: seg_decode = 7'b0110000;
            4'h4: seg_decode = 7'b0011001;
            4'h5: seg_decode = 7'b0010010;
            4'h6: seg_decode = 7'b0000010;
            4'h7: seg_decode = 7'b1111000;
            4'h8: seg_decode = 7'b0000000;
            4'h9: seg_decode = 7'b0010000;
            4'hA: seg_decode = 7'b0001000;
            4'hB: seg_decode = 7'b0000011;
            4'hC: seg_decode = 7'b1000110;
            4'hD: seg_decode = 7'b0100001;
            4'hE: seg_decode = 7'b0000110;
            default: seg_decode = 7'b0001110;
        endcase
    endfunction

    // Digit 0 is the fallback selection, so any out-of-range idx behaves as a wrap to 0.
    always_comb begin
        nib_d       = value_q[3:0];
        blank_d     = mask_q[0];
        sel_en_d    = '1;
        sel_en_d[0] = 1'b0;
        for (int i = 1; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                nib_d       = value_q[4*i +: 4];
                blank_d     = mask_q[i]
`ifdef SSD_LEADING_ZERO_BLANK_EN
                              | ((value_q >> (4*i)) == '0)
`endif
                              ;
                sel_en_d    = '1;
                sel_en_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        if (idx_q >= IW'(DIGITS-1)) idx_d = '0;
        else                        idx_d = idx_q + IW'(1);
    end

    // Outputs are built from the pre-edge counters and shadows, giving one cycle of latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= DEAD;
            div_cnt_q  <= '0;
            idx_q      <= '0;
            value_q    <= '0;
            mask_q     <= '0;
            ssd_bits_q <= 7'b1111111;
            digit_en_q <= '1;
        end else begin
            if (load_i) begin
                value_q <= value_i;
                mask_q  <= blank_mask_i;
            end
            if (div_cnt_q == DW'(REFRESH_DIV-1)) begin
                div_cnt_q <= '0;
                idx_q     <= idx_d;
                state_q   <= DEAD;
            end else begin
                div_cnt_q <= div_cnt_q + DW'(1);
                state_q   <= DRIVE;
            end
            case (state_q)
                DEAD: begin
                    ssd_bits_q <= 7'b1111111;
                    digit_en_q <= '1;
                end
                default: begin
                    ssd_bits_q <= blank_d ? 7'b1111111 : seg_decode(nib_d);
                    digit_en_q <= sel_en_d;
                end
            endcase
        end
    end

    assign ssd_bits_o = ssd_bits_q;
    assign digit_en_o = digit_en_q;
endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver: randomized loads checked against a slot/phase arithmetic model.
module tb_ssd_scan_driver;
    localparam int DIGITS = 4;
    localparam int RD     = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value_i = '0;
    logic        load_i = 1'b0;
    logic [3:0]  blank_mask_i = '0;
    logic [6:0]  ssd_bits_o;
    logic [3:0]  digit_en_o;

    ssd_scan_driver #(.DIGITS(DIGITS), .REFRESH_DIV(RD)) dut (
        .clk(clk), .rst_n(rst_n), .value_i(value_i), .load_i(load_i),
        .blank_mask_i(blank_mask_i), .ssd_bits_o(ssd_bits_o), .digit_en_o(digit_en_o)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    int          n_tests = 0;
    int          n_fail  = 0;
    int          p = 0;            // cycles elapsed since the reset edge
    logic [15:0] mv = '0;
    logic [3:0]  mm = '0;
    logic [6:0]  exp_ssd;
    logic [3:0]  exp_en;

    function automatic int cur_slot();
        return (p / RD) % DIGITS;
    endfunction

    // Applies one cycle of inputs and advances the model; expectation is left in exp_ssd/exp_en.
    task automatic tick(input logic r, input logic ld, input logic [15:0] v, input logic [3:0] m);
        int slot, ph;
        logic [15:0] upper;
        logic blank;
        rst_n = r; load_i = ld; value_i = v; blank_mask_i = m;
        @(posedge clk);
        if (!r) begin
            exp_ssd = 7'b1111111; exp_en = 4'b1111;
            p = 0; mv = '0; mm = '0;
        end else begin
            ph   = p % RD;
            slot = cur_slot();
            if (ph == 0) begin
                exp_ssd = 7'b1111111; exp_en = 4'b1111;
            end else begin
                exp_en = 4'b1111;
                exp_en[slot] = 1'b0;
                upper = mv >> (4*slot);
                blank = mm[slot];
`ifdef SSD_LEADING_ZERO_BLANK_EN
                if (slot > 0 && upper == 16'h0) blank = 1'b1;
`endif
                exp_ssd = blank ? 7'b1111111 : glyph[upper[3:0]];
            end
            if (ld) begin mv = v; mm = m; end
            p++;
        end
        #1;
    endtask

    task automatic run_check(input int cycles, input string name);
        for (int k = 0; k < cycles; k++) begin
            tick(1'b1, 1'b0, $urandom, $urandom);
            n_tests++;
            if (ssd_bits_o !== exp_ssd || digit_en_o !== exp_en) begin
                n_fail++;
                $display("FAIL %s cyc %0d: got ssd=%b en=%b, want ssd=%b en=%b",
                         name, k, ssd_bits_o, digit_en_o, exp_ssd, exp_en);
            end
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b0, 16'h0, 4'h0);
            n_tests++;
            if (ssd_bits_o !== 7'b1111111 || digit_en_o !== 4'b1111) begin
                n_fail++;
                $display("FAIL reset_hold: got ssd=%b en=%b, want 1111111 1111", ssd_bits_o, digit_en_o);
            end
        end
        tick(1'b1, 1'b0, 16'h0, 4'h0);
        n_tests++;
        if (ssd_bits_o !== 7'b1111111 || digit_en_o !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_first_dark: got ssd=%b en=%b, want 1111111 1111", ssd_bits_o, digit_en_o);
        end
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b0, 16'h0, 4'h0);
            n_tests++;
            if (ssd_bits_o !== 7'b1000000 || digit_en_o !== 4'b1110) begin
                n_fail++;
                $display("FAIL reset_digit0: got ssd=%b en=%b, want 1000000 1110", ssd_bits_o, digit_en_o);
            end
        end
    endtask

    task automatic test_scan_1234();
        tick(1'b1, 1'b1, 16'h1234, 4'h0);
        run_check(2*DIGITS*RD, "scan_1234");
    endtask

    task automatic test_sweep();
        for (int n = 0; n < 16; n++) begin
            logic [15:0] v;
            v = 16'($urandom);
            v[3:0] = 4'(n);
            tick(1'b1, 1'b1, v, 4'h0);
            run_check(DIGITS*RD, "sweep");
        end
    endtask

    task automatic test_mask();
        tick(1'b1, 1'b1, 16'hABCD, 4'b0100);
        run_check(2*DIGITS*RD, "mask_abcd");
    endtask

    task automatic test_leading_zero();
        tick(1'b1, 1'b1, 16'h0070, 4'h0);
        run_check(DIGITS*RD, "lz_0070");
        tick(1'b1, 1'b1, 16'h0000, 4'h0);
        run_check(DIGITS*RD, "lz_0000");
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            logic ld;
            ld = ($urandom_range(0, 3) == 0);
            tick(1'b1, ld, $urandom, $urandom);
            n_tests++;
            if (ssd_bits_o !== exp_ssd || digit_en_o !== exp_en) begin
                n_fail++;
                $display("FAIL random cyc %0d: got ssd=%b en=%b, want ssd=%b en=%b",
                         k, ssd_bits_o, digit_en_o, exp_ssd, exp_en);
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        tick(1'b1, 1'b1, 16'h5A5A, 4'h0);
        while (!(cur_slot() == 2 && (p % RD) == 2) && guard < 100) begin
            tick(1'b1, 1'b0, 16'h0, 4'h0);
            guard++;
        end
        n_tests++;
        if (guard >= 100) begin
            n_fail++;
            $display("FAIL reset_mid_align: got guard=%0d, want < 100", guard);
        end
        tick(1'b0, 1'b1, 16'hFFFF, 4'h0);
        n_tests++;
        if (ssd_bits_o !== 7'b1111111 || digit_en_o !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_mid_dark: got ssd=%b en=%b, want 1111111 1111", ssd_bits_o, digit_en_o);
        end
        tick(1'b1, 1'b0, 16'h0, 4'h0);
        n_tests++;
        if (ssd_bits_o !== 7'b1111111 || digit_en_o !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_mid_dead: got ssd=%b en=%b, want 1111111 1111", ssd_bits_o, digit_en_o);
        end
        tick(1'b1, 1'b0, 16'h0, 4'h0);
        n_tests++;
        if (ssd_bits_o !== 7'b1000000 || digit_en_o !== 4'b1110) begin
            n_fail++;
            $display("FAIL reset_mid_restart: got ssd=%b en=%b, want 1000000 1110", ssd_bits_o, digit_en_o);
        end
        run_check(DIGITS*RD, "reset_mid_after");
    endtask

    initial begin
        test_reset();
        test_scan_1234();
        test_sweep();
        test_mask();
        test_leading_zero();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
